sequence_player: RTL and testbench
==================================

// Module: sequence_player
// PURPOSE
//  Parametrised successor to the fixed 8 x 8-bit sequence generator: plays a programmable
//  table of DEPTH words of DATA_W bits onto a valid/ready stream. Supports loop, one-shot
//  and ping-pong modes, a run-time sequence length, enable gating and start/stop control.
//  Sits between the register/config interface (table load) and downstream stimulus sinks.
// PARAMETERS
//  DATA_W  8                width of each table word and of data
//  DEPTH   8                number of table entries (>=1)
//  ADDR_W  $clog2(DEPTH)>=1 table index width
// PORTS
//  clk        in   1         clock; all logic is rising-edge
//  rst_n      in   1         asynchronous active-low reset
//  wr_en      in   1         table write strobe
//  wr_addr    in   ADDR_W    table write index; writes with wr_addr>=DEPTH are ignored
//  wr_data    in   DATA_W    table write data
//  mode       in   2         00 loop, 01 one-shot, 10 ping-pong, 11 treated as loop; sampled on start
//  seq_len    in   ADDR_W+1  active entries L; sampled on start; 0 or >DEPTH means DEPTH
//  start      in   1         pulse: (re)start the sequence at entry 0
//  stop       in   1         pulse: abort to IDLE
//  en         in   1         output gate; low pauses playback
//  out_valid  out  1         data holds a sequence word
//  out_ready  in   1         downstream accepts data when out_valid&&out_ready
//  data       out  DATA_W    current word; 0 whenever out_valid=0
//  last       out  1         qualifies final word of one period (with out_valid)
//  done       out  1         level: one-shot sequence completed
//  busy       out  1         state is RUN
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, idx=0, dir=up, out_valid=0, data=0, last=0, done=0,
//    busy=0, all table entries=0. Deassertion is sampled synchronously.
//  - Table: a write takes effect at the next clock. The presented word is registered, so a
//    write to the presented index does not change data until the next advance.
//  - States: IDLE -> RUN on start. RUN -> DONE on acceptance of the final one-shot word.
//    RUN/DONE -> IDLE on stop. start in RUN or DONE restarts: idx=0, dir=up, done=0.
//    stop has priority over start in the same cycle.
//  - Latency: start at edge N -> out_valid=1 with table[0] after edge N+1 (if en=1).
//  - RUN, en=1: out_valid=1, data=table[idx]. On out_valid&&out_ready, idx advances and
//    data loads the next word at the same edge. Back-to-back acceptance gives 1 word/cycle.
//  - RUN, en=0: out_valid=0, data=0, idx and dir held. Playback resumes at the same index
//    one cycle after en returns high. A word is never skipped or repeated.
//  - out_ready low while out_valid=1: data, last and idx are held stable.
//  - Loop: idx 0..L-1, wraps to 0. last=1 at idx L-1.
//  - One-shot: idx 0..L-1. On acceptance at L-1: state=DONE, done=1, out_valid=0, data=0.
//    done stays high until start, stop or reset.
//  - Ping-pong: 0,1..L-1,L-2..1,0,1.. with endpoints not repeated. last=1 when idx=0 is
//    presented in dir=down, i.e. the end of a period. L=1: entry 0 repeats, last=1 on every word.
//  - L=1 in loop mode: entry 0 repeats with last=1 on every word.
//  - IDLE: out_valid=0, data=0, last=0, busy=0. en, out_ready and mode are ignored.
//  - Index arithmetic is done on ADDR_W+1 bits with no overflow past DEPTH-1.
// TESTING
//  1 Load table[i]=1<<i, mode=00, L=0, start, en=1, ready=1 -> data 01,02,04..80,01,02..
//    each word 1 cycle; last=1 only with 80; first word 1 cycle after start.
//  2 Same, ready=0 for 3 cycles while 04 is presented -> data=04, valid=1 held; then 08,10..
//  3 en=0 for 4 cycles while 10 is presented -> valid=0, data=00; en=1 -> 10 resumes, then 20.
//  4 mode=01, L=3 -> 01,02,04 (last on 04), then valid=0, done=1; start -> done=0, 01 again.
//  5 mode=10, L=4 -> 01,02,04,08,04,02,01,02..; last with the 01 that ends each period;
//    L=1 -> 01 repeated, last=1 on every word.
//  6 rst_n=0 mid-run (no clock edge) -> valid=0, data=0, busy=0 immediately;
//    after release, start -> data=00 (table cleared).

Source files
------------

// File: rtl/sequence_player.sv
// sequence_player: plays a programmable DEPTH x DATA_W table onto a valid/ready stream
// in loop, one-shot or ping-pong order, with run-time length, enable gating and start/stop.
module sequence_player #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [1:0]        mode,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data,
    output logic              last,
    output logic              done,
    output logic              busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    logic [1:0]        state_q, state_d, mode_q, mode_d;
    logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d, lm1, nxt_idx;
    logic              dir_q, dir_d, nxt_dir;
    logic              valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic              accept, wrap, pp;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // dir_q=1 means walking down (ping-pong only)
    always_comb begin
        pp      = mode_q == 2'b10;
        lm1     = len_q - ONE;
        wrap    = idx_q == lm1;
        nxt_dir = 1'b0;
        nxt_idx = wrap ? '0 : idx_q + ONE;
        if (pp) begin
            if (len_q == ONE) begin
                nxt_idx = '0;
            end else if (dir_q && idx_q == '0) begin
                nxt_idx = ONE;
            end else if (dir_q || wrap) begin
                nxt_idx = idx_q - ONE;
                nxt_dir = 1'b1;
            end
        end
    end

    always_comb begin
        accept  = valid_q && out_ready;
        mem_d   = mem_q;
        if (wr_en && {1'b0, wr_addr} < LEN_MAX) mem_d[wr_addr] = wr_data;
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        idx_d   = idx_q;
        dir_d   = dir_q;
        done_d  = done_q;
        valid_d = 1'b0;
        data_d  = '0;
        last_d  = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            idx_d   = '0;
            dir_d   = 1'b0;
            done_d  = 1'b0;
        end else if (start) begin
            state_d = S_RUN;
            mode_d  = mode;
            len_d   = (seq_len == '0 || seq_len > LEN_MAX) ? LEN_MAX : seq_len;
            idx_d   = '0;
            dir_d   = 1'b0;
            done_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            if (accept && mode_q == 2'b01 && wrap) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end else begin
                idx_d   = accept ? nxt_idx : idx_q;
                dir_d   = accept ? nxt_dir : dir_q;
                valid_d = en;
                // a stalled word is held rather than re-read, so table writes cannot alter it
                data_d  = !en ? '0 : (valid_q && !out_ready) ? data_q : mem_q[idx_d[ADDR_W-1:0]];
                last_d  = en && (pp ? (len_q == ONE || (dir_d && idx_d == '0)) : idx_d == lm1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            len_q   <= LEN_MAX;
            idx_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            mem_q   <= mem_d;
        end
    end

    assign out_valid = valid_q;
    assign data      = data_q;
    assign last      = last_q;
    assign done      = done_q;
    assign busy      = state_q == S_RUN;
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed stimulus with a queue of expected words popped on each handshake.
module tb_sequence_player;
    logic       clk = 1'b0;
    logic       rst_n, wr_en, start, stop, en, out_ready;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] mode;
    logic [3:0] seq_len;
    logic       out_valid, last, done, busy;
    logic [7:0] data;
    int         n_assert = 0;
    int         n_fail   = 0;
    int         cyc;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;
    exp_t sb[$];

    sequence_player dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mode(mode), .seq_len(seq_len), .start(start), .stop(stop), .en(en),
        .out_valid(out_valid), .out_ready(out_ready), .data(data), .last(last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        sb.push_back('{d: d, l: l});
    endtask

    task automatic consume(input int n, output int cycles);
        exp_t e;
        int   got = 0;
        cycles = 0;
        while (got < n && cycles < 4 * n + 10) begin
            if (out_valid === 1'b1 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("extra_word", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("data", data, e.d);
                    chk("last", last, e.l);
                end
                got++;
            end else begin
                chk("idle_data", data, 0);
            end
            tick();
            cycles++;
        end
        chk("word_count", got, n);
    endtask

    task automatic go(input logic [1:0] m, input logic [3:0] l);
        mode    = m;
        seq_len = l;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; mode = '0; seq_len = '0;
        start = 1'b0; stop = 1'b0; en = 1'b1; out_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", last, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_en_ignored", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(1 << i);
            tick();
        end
        wr_en = 1'b0;

        // loop, full length, back-to-back
        go(2'b00, 4'd0);
        chk("start_latency_valid", out_valid, 0);
        chk("start_busy", busy, 1);
        tick();
        chk("first_word_valid", out_valid, 1);
        for (int i = 0; i < 8; i++) push(8'(1 << i), i == 7);
        push(8'h01, 1'b0); push(8'h02, 1'b0);
        consume(10, cyc);
        chk("throughput_cycles", cyc, 10);

        // backpressure on 04
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1);
            chk("stall_data", data, 8'h04);
        end
        out_ready = 1'b1;
        push(8'h04, 1'b0);
        consume(1, cyc);

        // 08 accepted as en drops, so 10 waits
        push(8'h08, 1'b0);
        en = 1'b0;
        consume(1, cyc);
        for (int i = 0; i < 4; i++) begin
            chk("en_low_valid", out_valid, 0);
            chk("en_low_data", data, 0);
            tick();
        end
        en = 1'b1;
        push(8'h10, 1'b0); push(8'h20, 1'b0);
        consume(2, cyc);

        // one-shot L=3
        go(2'b01, 4'd3);
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h04, 1'b1);
        consume(3, cyc);
        chk("oneshot_valid", out_valid, 0);
        chk("oneshot_done", done, 1);
        chk("oneshot_busy", busy, 0);
        chk("oneshot_data", data, 0);
        tick();
        chk("done_sticky", done, 1);
        go(2'b01, 4'd3);
        chk("restart_done_clr", done, 0);
        push(8'h01, 1'b0);
        consume(1, cyc);

        // ping-pong L=4
        go(2'b10, 4'd4);
        push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h04, 1'b0); push(8'h08, 1'b0);
        push(8'h04, 1'b0); push(8'h02, 1'b0); push(8'h01, 1'b1); push(8'h02, 1'b0);
        push(8'h04, 1'b0);
        consume(9, cyc);

        // ping-pong and loop with L=1
        go(2'b10, 4'd1);
        for (int i = 0; i < 4; i++) push(8'h01, 1'b1);
        consume(4, cyc);
        go(2'b00, 4'd1);
        for (int i = 0; i < 3; i++) push(8'h01, 1'b1);
        consume(3, cyc);

        // mode 11 as loop with L>DEPTH clamped to 8
        go(2'b11, 4'd9);
        for (int i = 0; i < 8; i++) push(8'(1 << i), i == 7);
        push(8'h01, 1'b0);
        consume(9, cyc);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", busy, 0);
        chk("stop_valid", out_valid, 0);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("stop_priority_busy", busy, 0);
        tick();
        chk("stop_priority_valid", out_valid, 0);

        // write to the stalled index must not disturb the presented word
        out_ready = 1'b0;
        go(2'b00, 4'd2);
        tick();
        chk("pre_write_data", data, 8'h01);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hAA;
        tick();
        wr_en = 1'b0;
        chk("held_after_write", data, 8'h01);
        out_ready = 1'b1;
        push(8'h01, 1'b0); push(8'h02, 1'b1); push(8'hAA, 1'b0);
        consume(3, cyc);

        // async reset mid-run
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_data", data, 0);
        chk("async_rst_busy", busy, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        go(2'b00, 4'd0);
        tick();
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_data", data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
